// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder: expands RL7/RL3 command bytes into 8-bit colour indices for one line.
// Optional RLE_ERROR_EN adds a sticky err_overrun output for truncated runs and input underrun.
module rle_pixel_decoder #(
    parameter int COL_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rl3_mode,
    input  logic [COL_BITS-1:0] line_width,
    input  logic                line_start,
    output logic                line_done,
    input  logic                in_write,
    input  logic [7:0]          in_pixel,
    output logic                in_strobe,
    output logic                out_write,
    output logic [7:0]          out_pixel,
    input  logic                out_strobe
`ifdef RLE_ERROR_EN
    ,
    output logic                err_overrun
`endif
);

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_COUNT = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COL_BITS-1:0] ONE     = COL_BITS'(1);
    localparam logic [COL_BITS:0]   ONE_EXT = (COL_BITS + 1)'(1);

    state_t              state_q;
    logic                mode_q;
    logic [COL_BITS-1:0] width_q;
    logic [COL_BITS-1:0] column_q;
    logic [COL_BITS-1:0] rem_q;
    logic                half_q;
    logic [2:0]          col_a_q;
    logic [2:0]          col_b_q;
    logic [7:0]          pixel_q;
    logic                line_done_q;

    logic [COL_BITS-1:0] col_next_d;
    logic [COL_BITS-1:0] line_left_d;
    logic [COL_BITS:0]   left_ext_d;
    logic [COL_BITS-1:0] pairs_left_d;
    logic                eol_hit_d;
    logic                run_end_d;

    assign col_next_d   = column_q + ONE;
    assign line_left_d  = width_q - column_q;
    // Wide by one bit so a 1023-pixel remainder still rounds up to 512 pairs.
    assign left_ext_d   = {1'b0, line_left_d} + ONE_EXT;
    assign pairs_left_d = left_ext_d[COL_BITS:1];
    assign eol_hit_d    = (col_next_d == width_q);
    assign run_end_d    = mode_q ? (half_q && (rem_q == ONE)) : (rem_q == ONE);

    assign in_strobe = in_write && ((state_q == S_CMD) || (state_q == S_COUNT)) && !line_start;
    assign out_write = (state_q == S_EMIT);
    assign out_pixel = pixel_q;
    assign line_done = line_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_DONE;
            mode_q      <= 1'b0;
            width_q     <= '0;
            column_q    <= '0;
            rem_q       <= '0;
            half_q      <= 1'b0;
            col_a_q     <= 3'd0;
            col_b_q     <= 3'd0;
            pixel_q     <= 8'd0;
            line_done_q <= 1'b1;
        end else if (line_start) begin
            mode_q   <= rl3_mode;
            width_q  <= line_width;
            column_q <= '0;
            rem_q    <= '0;
            half_q   <= 1'b0;
            if (line_width == '0) begin
                state_q     <= S_DONE;
                line_done_q <= 1'b1;
            end else begin
                state_q     <= S_CMD;
                line_done_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_CMD: begin
                    if (in_write) begin
                        if (mode_q) begin
                            col_a_q <= in_pixel[6:4];
                            col_b_q <= in_pixel[2:0];
                            pixel_q <= {5'd0, in_pixel[6:4]};
                        end else begin
                            pixel_q <= {1'b0, in_pixel[6:0]};
                        end
                        if (in_pixel[7]) begin
                            state_q <= S_COUNT;
                        end else begin
                            rem_q   <= ONE;
                            state_q <= S_EMIT;
                        end
                    end
                end
                S_COUNT: begin
                    if (in_write) begin
                        if (in_pixel != 8'd0) begin
                            rem_q <= COL_BITS'(in_pixel);
                        end else begin
                            rem_q <= mode_q ? pairs_left_d : line_left_d;
                        end
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_strobe) begin
                        column_q <= col_next_d;
                        if (mode_q) begin
                            if (!half_q) begin
                                half_q  <= 1'b1;
                                pixel_q <= {5'd0, col_b_q};
                            end else begin
                                half_q  <= 1'b0;
                                rem_q   <= rem_q - ONE;
                                pixel_q <= {5'd0, col_a_q};
                            end
                        end else begin
                            rem_q <= rem_q - ONE;
                        end
                        // End of line wins over end of run, even part-way through a pair.
                        if (eol_hit_d) begin
                            state_q     <= S_DONE;
                            line_done_q <= 1'b1;
                        end else if (run_end_d) begin
                            state_q <= S_CMD;
                        end
                    end
                end
                default: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

`ifdef RLE_ERROR_EN
    logic       err_q;
    logic [6:0] idle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q  <= 1'b0;
            idle_q <= 7'd0;
        end else if (line_start) begin
            err_q  <= 1'b0;
            idle_q <= 7'd0;
        end else begin
            if (((state_q == S_CMD) || (state_q == S_COUNT)) && !in_write) begin
                if (idle_q != 7'd64) begin
                    idle_q <= idle_q + 7'd1;
                end
                if (idle_q >= 7'd63) begin
                    err_q <= 1'b1;
                end
            end else begin
                idle_q <= 7'd0;
            end
            if ((state_q == S_EMIT) && out_strobe && eol_hit_d &&
                ((rem_q > ONE) || (mode_q && !half_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_overrun = err_q;
`endif

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Randomised and directed bench for rle_pixel_decoder against a queue-based line model.
module tb_rle_pixel_decoder;
    localparam int CB = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          rl3_mode;
    logic [CB-1:0] line_width;
    logic          line_start;
    logic          line_done;
    logic          in_write;
    logic [7:0]    in_pixel;
    logic          in_strobe;
    logic          out_write;
    logic [7:0]    out_pixel;
    logic          out_strobe;
`ifdef RLE_ERROR_EN
    logic          err_overrun;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] bytes_q[$];
    logic [7:0] exp_pix[$];
    logic [7:0] got_pix[$];
    int         exp_consumed;
    bit         exp_done;
    bit         exp_err;

    rle_pixel_decoder #(.COL_BITS(CB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rl3_mode   (rl3_mode),
        .line_width (line_width),
        .line_start (line_start),
        .line_done  (line_done),
        .in_write   (in_write),
        .in_pixel   (in_pixel),
        .in_strobe  (in_strobe),
        .out_write  (out_write),
        .out_pixel  (out_pixel),
        .out_strobe (out_strobe)
`ifdef RLE_ERROR_EN
        ,
        .err_overrun(err_overrun)
`endif
    );

    always #5 clk = ~clk;

    // Expected pixels, bytes consumed, completion and truncation for one line.
    task automatic model(input bit mode, input int width);
        int col;
        int i;
        int cnt;
        int npix;
        logic [7:0] b;
        logic [7:0] ca;
        logic [7:0] cb;
        exp_pix.delete();
        col = 0;
        i = 0;
        exp_done = (width == 0);
        exp_err = 1'b0;
        while (!exp_done && i < bytes_q.size()) begin
            b = bytes_q[i];
            i++;
            if (mode) begin
                ca = {5'd0, b[6:4]};
                cb = {5'd0, b[2:0]};
            end else begin
                ca = {1'b0, b[6:0]};
                cb = ca;
            end
            cnt = 1;
            if (b[7]) begin
                cnt = int'(bytes_q[i]);
                i++;
                if (cnt == 0) cnt = mode ? (width - col + 1) / 2 : (width - col);
            end
            npix = mode ? 2 * cnt : cnt;
            for (int k = 0; k < npix; k++) begin
                exp_pix.push_back((k % 2 == 1) ? cb : ca);
                col++;
                if (col == width) begin
                    exp_done = 1'b1;
                    if (k < npix - 1) exp_err = 1'b1;
                    break;
                end
            end
        end
        exp_consumed = i;
    endtask

    task automatic start_line(input bit mode, input int width);
        @(negedge clk);
        rl3_mode   = mode;
        line_width = width[CB-1:0];
        line_start = 1'b1;
        in_write   = 1'b0;
        out_strobe = 1'b0;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // strobe_mode: 0 always, 1 alternate, 2 random. wr_rand: random gaps on in_write.
    task automatic run_line(input bit mode, input int width, input int strobe_mode, input int wr_rand);
        int idx = 0;
        int pidx = 0;
        int cyc = 0;
        bit hold = 1'b0;
        bit fin = 1'b0;
        logic [7:0] held = 8'd0;
        model(mode, width);
        got_pix.delete();
        start_line(mode, width);
        while (!fin) begin
            in_write = (idx < bytes_q.size()) && (wr_rand == 0 || $urandom_range(0, 3) != 0);
            in_pixel = (idx < bytes_q.size()) ? bytes_q[idx] : 8'h00;
            case (strobe_mode)
                0:       out_strobe = 1'b1;
                1:       out_strobe = (cyc % 2 == 0);
                default: out_strobe = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (hold) begin
                checks++;
                if (out_write !== 1'b1 || out_pixel !== held) begin
                    failures++;
                    $display("FAIL stall_hold: out_write=%b out_pixel=%h required 1 %h", out_write, out_pixel, held);
                end
            end
            if (in_strobe) idx++;
            if (out_write && out_strobe) begin
                checks++;
                if (pidx >= exp_pix.size() || out_pixel !== exp_pix[pidx]) begin
                    failures++;
                    $display("FAIL pixel[%0d]: got %h required %h", pidx, out_pixel,
                             (pidx < exp_pix.size()) ? exp_pix[pidx] : 8'hxx);
                end
                got_pix.push_back(out_pixel);
                pidx++;
            end
            hold = out_write && !out_strobe;
            held = out_pixel;
            cyc++;
            @(negedge clk);
            if (line_done || (idx == bytes_q.size() && pidx == exp_pix.size() && !exp_done)) begin
                fin = 1'b1;
            end else if (cyc > 3000) begin
                checks++;
                failures++;
                $display("FAIL line_timeout: pixels=%0d required %0d", pidx, exp_pix.size());
                fin = 1'b1;
            end
        end
        in_write = 1'b0;
        out_strobe = 1'b0;
        checks++;
        if (pidx != exp_pix.size()) begin
            failures++;
            $display("FAIL pixel_count: got %0d required %0d", pidx, exp_pix.size());
        end
        checks++;
        if (idx != exp_consumed) begin
            failures++;
            $display("FAIL bytes_consumed: got %0d required %0d", idx, exp_consumed);
        end
        checks++;
        if (line_done !== exp_done) begin
            failures++;
            $display("FAIL line_done: got %b required %b", line_done, exp_done);
        end
`ifdef RLE_ERROR_EN
        checks++;
        if (err_overrun !== exp_err) begin
            failures++;
            $display("FAIL err_overrun: got %b required %b", err_overrun, exp_err);
        end
`endif
        if (exp_done) begin
            for (int c = 0; c < 6; c++) begin
                in_write = 1'b1;
                in_pixel = 8'h05;
                out_strobe = 1'b1;
                #1;
                checks++;
                if (in_strobe !== 1'b0 || out_write !== 1'b0) begin
                    failures++;
                    $display("FAIL after_done: in_strobe=%b out_write=%b required 0 0", in_strobe, out_write);
                end
                @(negedge clk);
            end
            in_write = 1'b0;
            out_strobe = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_write = 1'b1;
        in_pixel = 8'h05;
        #1;
        checks++;
        if (out_write !== 1'b0 || out_pixel !== 8'd0 || in_strobe !== 1'b0 || line_done !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: ow=%b op=%h is=%b ld=%b required 0 00 0 1",
                     out_write, out_pixel, in_strobe, line_done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (in_strobe !== 1'b0 || line_done !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset: in_strobe=%b line_done=%b required 0 1", in_strobe, line_done);
        end
        in_write = 1'b0;
    endtask

    task automatic test_rl7_single;
        logic [7:0] want[4] = '{8'h05, 8'h06, 8'h07, 8'h08};
        bytes_q = '{8'h05, 8'h06, 8'h07, 8'h08};
        run_line(1'b0, 4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_pix.size() || got_pix[i] !== want[i]) begin
                failures++;
                $display("FAIL rl7_single[%0d]: got %h required %h", i,
                         (i < got_pix.size()) ? got_pix[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_rl7_run;
        logic [7:0] want[5] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h11};
        bytes_q = '{8'h83, 8'h04, 8'h11};
        run_line(1'b0, 10, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got_pix.size() || got_pix[i] !== want[i]) begin
                failures++;
                $display("FAIL rl7_run[%0d]: got %h required %h", i,
                         (i < got_pix.size()) ? got_pix[i] : 8'hxx, want[i]);
            end
        end
        in_write = 1'b1;
        in_pixel = 8'h00;
        #1;
        checks++;
        if (in_strobe !== 1'b1 || out_write !== 1'b0) begin
            failures++;
            $display("FAIL rl7_run_cmd_wait: in_strobe=%b out_write=%b required 1 0", in_strobe, out_write);
        end
        in_write = 1'b0;
    endtask

    task automatic test_run_to_eol;
        bytes_q = '{8'h02, 8'hAA, 8'h00, 8'h05};
        run_line(1'b0, 8, 0, 1);
        checks++;
        if (got_pix.size() != 8 || got_pix[0] !== 8'h02 || got_pix[7] !== 8'h2A) begin
            failures++;
            $display("FAIL run_to_eol: count=%0d required 8 ending in 2a", got_pix.size());
        end
    endtask

    task automatic test_rl3;
        logic [7:0] want[6] = '{8'h05, 8'h03, 8'h05, 8'h03, 8'h01, 8'h02};
        bytes_q = '{8'hD3, 8'h02, 8'h12};
        run_line(1'b1, 6, 2, 1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got_pix.size() || got_pix[i] !== want[i]) begin
                failures++;
                $display("FAIL rl3[%0d]: got %h required %h", i,
                         (i < got_pix.size()) ? got_pix[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        bytes_q = '{8'h81, 8'h10};
        run_line(1'b0, 3, 1, 0);
        checks++;
        if (got_pix.size() != 3 || got_pix[2] !== 8'h01) begin
            failures++;
            $display("FAIL backpressure: count=%0d required 3 of 01", got_pix.size());
        end
`ifdef RLE_ERROR_EN
        checks++;
        if (err_overrun !== 1'b1) begin
            failures++;
            $display("FAIL truncation_err: got %b required 1", err_overrun);
        end
`endif
    endtask

    task automatic test_zero_width;
        bytes_q = '{8'h05};
        run_line(1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run;
        start_line(1'b0, 10);
        in_write = 1'b1;
        in_pixel = 8'h85;
        @(negedge clk);
        in_pixel = 8'h00;
        @(negedge clk);
        in_write = 1'b0;
        out_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_write !== 1'b1 || out_pixel !== 8'h05) begin
            failures++;
            $display("FAIL mid_run_emit: out_write=%b out_pixel=%h required 1 05", out_write, out_pixel);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_write !== 1'b0 || line_done !== 1'b1 || out_pixel !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: ow=%b ld=%b op=%h required 0 1 00", out_write, line_done, out_pixel);
        end
        out_strobe = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bytes_q = '{8'h09};
        run_line(1'b0, 2, 0, 0);
        checks++;
        if (got_pix.size() < 1 || got_pix[0] !== 8'h09) begin
            failures++;
            $display("FAIL post_reset_pixel: got %h required 09", (got_pix.size() > 0) ? got_pix[0] : 8'hxx);
        end
    endtask

`ifdef RLE_ERROR_EN
    task automatic test_underrun;
        start_line(1'b0, 5);
        repeat (70) @(negedge clk);
        checks++;
        if (err_overrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_err: got %b required 1", err_overrun);
        end
        start_line(1'b0, 5);
        checks++;
        if (err_overrun !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got %b required 0", err_overrun);
        end
    endtask
`endif

    task automatic test_random;
        bit mode;
        int width;
        int cov;
        logic [7:0] b;
        logic [7:0] c;
        for (int n = 0; n < 10; n++) begin
            mode = bit'($urandom_range(0, 1));
            width = $urandom_range(1, 40);
            bytes_q.delete();
            cov = 0;
            while (cov < width) begin
                b = 8'($urandom_range(0, 255));
                bytes_q.push_back(b);
                if (b[7]) begin
                    c = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
                    bytes_q.push_back(c);
                    cov += (c == 8'd0) ? width : (mode ? 2 * int'(c) : int'(c));
                end else begin
                    cov += mode ? 2 : 1;
                end
            end
            bytes_q.push_back(8'($urandom_range(0, 255)));
            bytes_q.push_back(8'($urandom_range(0, 255)));
            run_line(mode, width, 2, 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        rl3_mode = 1'b0;
        line_width = '0;
        line_start = 1'b0;
        in_write = 1'b0;
        in_pixel = 8'd0;
        out_strobe = 1'b0;
        test_reset;
        test_rl7_single;
        test_rl7_run;
        test_run_to_eol;
        test_rl3;
        test_backpressure;
        test_zero_width;
        test_reset_mid_run;
`ifdef RLE_ERROR_EN
        test_underrun;
`endif
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
